// File: rtl/rx_slicer_ber_pkg.sv
// rx_slicer_ber_pkg: shared constants, level codes, FSM state type and helpers
// for the 16-QAM receive slicer / BER counter.
// Contents: QAM levels, 2-bit level codes, rxb_state_t, popcount4().
package rx_slicer_ber_pkg;

    // Inner constellation level a (1s17) and the outer decision threshold 2a.
    localparam int QAM_INNER  = 16384;
    localparam int QAM_THRESH = 32768;

    // Length of the transmit-side PRBS generator that produces the reference.
    localparam int LFSR_LEN = 15;

    // Reference delay line depth (entries of 4-bit symbols).
    localparam int DLY_DEPTH = 32;

    // Sample type carried on both rails.
    typedef logic signed [17:0] sample_t;

    // Per-rail 2-bit level codes; exact inverse of the TX mapper.
    typedef logic [1:0] lvl_t;
    localparam lvl_t LVL_P3 = 2'b10;   // +3a
    localparam lvl_t LVL_P1 = 2'b11;   // +a
    localparam lvl_t LVL_M1 = 2'b01;   // -a
    localparam lvl_t LVL_M3 = 2'b00;   // -3a

    // Measurement FSM states.
    typedef enum logic [1:0] {
        RXB_IDLE    = 2'd0,
        RXB_MEASURE = 2'd1,
        RXB_DONE    = 2'd2
    } rxb_state_t;

    // Number of set bits in a 4-bit symbol difference (0..4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            n = n + {2'b00, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rx_slicer_ber_if.sv
// rx_slicer_ber_if: sample/reference/control inputs and decision/count outputs
// of the rx_slicer_ber block, bundled for port connection.
// Modports: master = stimulus side (drives samples, reads counts), slave = block.
interface rx_slicer_ber_if;
    import rx_slicer_ber_pkg::*;

    // Sample stream from the RX matched filter (4 samples per symbol).
    logic        sample_en;
    logic [1:0]  phase_sel;
    sample_t     in_phs_sig;
    sample_t     quad_sig;

    // Local reference symbol stream.
    logic [3:0]  ref_sym;
    logic        ref_valid;

    // Measurement control.
    logic        start;

    // Decisions.
    logic [3:0]  sym_out;
    logic        sym_valid;

    // Measurement status and results.
    logic        busy;
    logic        done;
    logic [21:0] sym_count;
    logic [21:0] sym_err_count;
    logic [23:0] bit_err_count;

    modport master (
        output sample_en, phase_sel, in_phs_sig, quad_sig,
        output ref_sym, ref_valid, start,
        input  sym_out, sym_valid, busy, done,
        input  sym_count, sym_err_count, bit_err_count
    );

    modport slave (
        input  sample_en, phase_sel, in_phs_sig, quad_sig,
        input  ref_sym, ref_valid, start,
        output sym_out, sym_valid, busy, done,
        output sym_count, sym_err_count, bit_err_count
    );

endinterface

// File: rtl/rx_slicer_ber_slicer.sv
// slicer_4_level: registered 4-level decision on one signed 1s17 rail.
// Latency: decision registered one cycle after en.
// Backpressure: none; en is a strobe, the decision holds between strobes.
// Ports: clk, reset_n, en (capture strobe), x (sample), dec (2-bit level code).
module slicer_4_level
    import rx_slicer_ber_pkg::*;
#(
    parameter sample_t THRESH = 18'sd32768
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    en,
    input  sample_t x,
    output lvl_t    dec
);

    localparam sample_t NEG_THRESH = -THRESH;
    localparam sample_t ZERO       = 18'sd0;

    // Boundaries belong to the upper region: x == THRESH is +3a, x == 0 is +a,
    // x == -THRESH is -a.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec <= LVL_M3;
        end else if (en) begin
            if (x >= THRESH) begin
                dec <= LVL_P3;
            end else if (x >= ZERO) begin
                dec <= LVL_P1;
            end else if (x >= NEG_THRESH) begin
                dec <= LVL_M1;
            end else begin
                dec <= LVL_M3;
            end
        end
    end

endmodule

// File: rtl/rx_slicer_ber.sv
// rx_slicer_ber: decimate-by-4, 16-QAM slice, compare against delayed reference, count errors.
// Latency: sym_out/sym_valid 1 cycle after the decimating sample_en; counts 1 cycle later.
// Backpressure: none; free-running strobes, decisions are produced in every state.
// Ports: clk, reset_n (async active-low), bus (rx_slicer_ber_if.slave: samples,
//        phase_sel, ref_sym/ref_valid, start in; sym_out/sym_valid, busy, done, counts out).
module rx_slicer_ber
    import rx_slicer_ber_pkg::*;
#(
    parameter sample_t     THRESH    = 18'sd32768,
    parameter logic [21:0] WINDOW    = 22'd1048576,
    parameter logic [4:0]  REF_DELAY = 5'd16
) (
    input  logic           clk,
    input  logic           reset_n,
    rx_slicer_ber_if.slave bus
);

    // ------------------------------------------------------------------
    // Sample phase tracking and decimation
    // ------------------------------------------------------------------
    logic [1:0] smp_cnt;
    logic [1:0] phase_lat;
    logic       decim;

    assign decim = bus.sample_en && (smp_cnt == phase_lat);

    // phase_sel is only taken at the symbol boundary so a change can never
    // yield two decisions (or none) inside one symbol.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp_cnt   <= 2'd0;
            phase_lat <= 2'd0;
        end else if (bus.sample_en) begin
            smp_cnt <= smp_cnt + 2'd1;
            if (smp_cnt == 2'd3) begin
                phase_lat <= bus.phase_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-rail slicers
    // ------------------------------------------------------------------
    lvl_t i_dec;
    lvl_t q_dec;
    logic sym_valid_q;

    slicer_4_level #(.THRESH(THRESH)) u_slice_i (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (decim),
        .x       (bus.in_phs_sig),
        .dec     (i_dec)
    );

    slicer_4_level #(.THRESH(THRESH)) u_slice_q (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (decim),
        .x       (bus.quad_sig),
        .dec     (q_dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_valid_q <= 1'b0;
        end else begin
            sym_valid_q <= decim;
        end
    end

    assign bus.sym_out   = {i_dec, q_dec};
    assign bus.sym_valid = sym_valid_q;

    // ------------------------------------------------------------------
    // Reference delay line
    // ------------------------------------------------------------------
    logic [3:0] dly [0:DLY_DEPTH-1];
    logic [3:0] ref_tap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DLY_DEPTH; k++) begin
                dly[k] <= 4'd0;
            end
        end else if (bus.ref_valid) begin
            dly[0] <= bus.ref_sym;
            for (int k = 1; k < DLY_DEPTH; k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

    // Read combinationally from the current register contents, so a shift in
    // the same cycle as sym_valid is not seen by this compare.
    assign ref_tap = dly[REF_DELAY];

    // ------------------------------------------------------------------
    // Error measurement
    // ------------------------------------------------------------------
    logic [3:0]  sym_diff;
    logic [2:0]  bit_diff;
    logic [21:0] sym_cnt_nxt;
    logic [24:0] bit_sum;

    assign sym_diff    = bus.sym_out ^ ref_tap;
    assign bit_diff    = popcount4(sym_diff);
    assign sym_cnt_nxt = bus.sym_count + 22'd1;
    assign bit_sum     = {1'b0, bus.bit_err_count} + {22'd0, bit_diff};

    rxb_state_t  state;
    logic        busy_q;
    logic        done_q;
    logic [21:0] sym_cnt_q;
    logic [21:0] sym_err_q;
    logic [23:0] bit_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RXB_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sym_cnt_q <= 22'd0;
            sym_err_q <= 22'd0;
            bit_err_q <= 24'd0;
        end else if (bus.start) begin
            // Start from any state clears and (re)arms; it also wins over a
            // symbol arriving in the same cycle.
            state     <= RXB_MEASURE;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            sym_cnt_q <= 22'd0;
            sym_err_q <= 22'd0;
            bit_err_q <= 24'd0;
        end else begin
            case (state)
                RXB_MEASURE: begin
                    if (sym_valid_q) begin
                        sym_cnt_q <= sym_cnt_nxt;
                        if ((sym_diff != 4'd0) && (sym_err_q != '1)) begin
                            sym_err_q <= sym_err_q + 22'd1;
                        end
                        bit_err_q <= bit_sum[24] ? '1 : bit_sum[23:0];
                        if (sym_cnt_nxt == WINDOW) begin
                            state  <= RXB_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                RXB_IDLE, RXB_DONE: begin
                    // Counts frozen until the next start.
                end
                default: begin
                    state  <= RXB_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sym_count     = sym_cnt_q;
    assign bus.sym_err_count = sym_err_q;
    assign bus.bit_err_count = bit_err_q;

endmodule

// File: tb/tb_rx_slicer_ber.sv
// tb_rx_slicer_ber: drives rx_slicer_ber through directed and random sample/reference
// streams and compares every cycle against a symbol-level reference model.
module tb_rx_slicer_ber;

    localparam int WIN   = 100;
    localparam int REF_D = 5;
    localparam int THR   = 32768;
    localparam int SERR_MAX = (1 << 22) - 1;
    localparam int BERR_MAX = (1 << 24) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rx_slicer_ber_if bus ();

    rx_slicer_ber #(
        .THRESH    (18'sd32768),
        .WINDOW    (22'd100),
        .REF_DELAY (5'd5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (symbol-level view of the block).
    int         sidx;        // position of the next sample within its symbol
    int         ph_lat;      // phase in force for the current symbol
    logic [3:0] hist_q[$];   // reference history, index 0 = newest
    bit         meas;
    bit         m_done;
    int         m_cnt, m_serr, m_berr;
    bit         pend;        // a decision is on sym_out this cycle
    logic [3:0] last_sym;

    logic [3:0] syms [0:511];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] slice(input int x);
        if (x >= THR)       return 2'b10;
        else if (x >= 0)    return 2'b11;
        else if (x >= -THR) return 2'b01;
        else                return 2'b00;
    endfunction

    function automatic int lvl(input logic [1:0] b);
        case (b)
            2'b10:   return 49152;
            2'b11:   return 16384;
            2'b01:   return -16384;
            default: return -49152;
        endcase
    endfunction

    task automatic model_reset();
        sidx = 0; ph_lat = 0;
        hist_q.delete();
        for (int k = 0; k < 32; k++) hist_q.push_back(4'd0);
        meas = 0; m_done = 0;
        m_cnt = 0; m_serr = 0; m_berr = 0;
        pend = 0; last_sym = 4'd0;
    endtask

    task automatic step(input bit en, input int iv, input int qv, input bit [1:0] ph,
                        input bit rv, input bit [3:0] rs, input bit st);
        bit         decim;
        logic [3:0] d;
        bus.sample_en  = en;
        bus.phase_sel  = ph;
        bus.in_phs_sig = 18'(iv);
        bus.quad_sig   = 18'(qv);
        bus.ref_valid  = rv;
        bus.ref_sym    = rs;
        bus.start      = st;
        if (st) begin
            meas = 1; m_done = 0; m_cnt = 0; m_serr = 0; m_berr = 0;
        end else if (pend && meas) begin
            d = last_sym ^ hist_q[REF_D];
            m_cnt++;
            if (d != 0 && m_serr < SERR_MAX) m_serr++;
            m_berr = m_berr + $countones(d);
            if (m_berr > BERR_MAX) m_berr = BERR_MAX;
            if (m_cnt == WIN) begin meas = 0; m_done = 1; end
        end
        if (rv) begin
            hist_q.push_front(rs);
            void'(hist_q.pop_back());
        end
        decim = en && (sidx == ph_lat);
        if (decim) last_sym = {slice(iv), slice(qv)};
        if (en) begin
            if (sidx == 3) ph_lat = ph;
            sidx = (sidx + 1) % 4;
        end
        pend = decim;
        @(posedge clk); #1;
        chk("sym_valid", bus.sym_valid, decim);
        chk("sym_out", bus.sym_out, last_sym);
        chk("busy", bus.busy, meas);
        chk("done", bus.done, m_done);
        chk("sym_count", bus.sym_count, m_cnt);
        chk("sym_err_count", bus.sym_err_count, m_serr);
        chk("bit_err_count", bus.bit_err_count, m_berr);
    endtask

    task automatic idle_inputs();
        bus.sample_en = 0; bus.phase_sel = 0; bus.in_phs_sig = '0; bus.quad_sig = '0;
        bus.ref_valid = 0; bus.ref_sym = 0; bus.start = 0;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_sym_out", bus.sym_out, 0);
        chk("rst_sym_valid", bus.sym_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sym_count", bus.sym_count, 0);
        chk("rst_sym_err", bus.sym_err_count, 0);
        chk("rst_bit_err", bus.bit_err_count, 0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_pulse();
        step(0, 0, 0, 2'd0, 0, 4'd0, 1);
    endtask

    // One symbol, all four samples at the mapped level, reference pushed on sample 0.
    task automatic send_sym(input logic [3:0] s, input bit inv_i, input bit [1:0] ph,
                            input logic [3:0] rs);
        int iv;
        iv = inv_i ? -lvl(s[3:2]) : lvl(s[3:2]);
        for (int k = 0; k < 4; k++) step(1, iv, lvl(s[1:0]), ph, k == 0, rs, 0);
    endtask

    // Symbols first..first+n-1; reference leads the transmitted stream by REF_D.
    task automatic run_syms(input int first, input int n, input bit inject);
        for (int k = first; k < first + n; k++)
            send_sym(syms[k], inject && (((k - first) % 10) == 9), 2'd0, syms[k + REF_D]);
    endtask

    task automatic fill_syms();
        for (int k = 0; k < 512; k++) syms[k] = 4'($urandom_range(0, 15));
    endtask

    int edge_v [6] = '{32768, 32767, 0, -1, -32768, -32769};
    logic [1:0] edge_e [6] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};

    initial begin
        int pulses;
        bit [1:0] rph;
        int iv, qv;
        model_reset();
        do_reset(3);

        // Static decisions: +3a / -3a held, phase 0.
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step(1, 49152, -49152, 2'd0, 0, 4'd0, 0);
            if (bus.sym_valid) pulses++;
        end
        chk("static_sym", bus.sym_out, 4'b1000);
        chk("static_pulses", pulses, 4);

        // Threshold edges on I.
        for (int e = 0; e < 6; e++) begin
            step(1, edge_v[e], 0, 2'd0, 0, 4'd0, 0);
            chk("edge_i_bits", bus.sym_out[3:2], edge_e[e]);
            for (int k = 1; k < 4; k++) step(1, edge_v[e], 0, 2'd0, 0, 4'd0, 0);
        end

        // Phase select 2: arm during one symbol, then only sample 2 is distinct.
        for (int k = 0; k < 4; k++) step(1, -49152, -49152, 2'd2, 0, 4'd0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                step(1, 49152, 49152, 2'd2, 0, 4'd0, 0);
                chk("phase2_sym", bus.sym_out, 4'b1010);
            end else begin
                step(1, -49152, -49152, 2'd2, 0, 4'd0, 0);
            end
        end
        // Mid-symbol change 2 -> 0: one decision per symbol across the change.
        pulses = 0;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 4; k++) begin
                step(1, 16384 * (k + 1), -16384, (s == 0 && k < 2) ? 2'd2 : 2'd0, 0, 4'd0, 0);
                if (bus.sym_valid) pulses++;
            end
        chk("phase_change_pulses", pulses, 3);

        // Clean loopback with matched reference delay.
        fill_syms();
        do_reset(2);
        run_syms(0, REF_D, 0);
        start_pulse();
        run_syms(REF_D, WIN - 1, 0);
        chk("lb_done_early", bus.done, 0);
        run_syms(REF_D + WIN - 1, 1, 0);
        chk("lb_done", bus.done, 1);
        chk("lb_count", bus.sym_count, WIN);
        chk("lb_sym_err", bus.sym_err_count, 0);
        chk("lb_bit_err", bus.bit_err_count, 0);

        // Error injection: every 10th symbol has its I sign flipped.
        fill_syms();
        do_reset(2);
        run_syms(0, REF_D, 0);
        start_pulse();
        run_syms(REF_D, WIN, 1);
        chk("inj_done", bus.done, 1);
        chk("inj_sym_err", bus.sym_err_count, 10);
        chk("inj_bit_err", bus.bit_err_count, 10);
        // Restart, then restart again mid-window.
        start_pulse();
        run_syms(REF_D + 100, 50, 0);
        start_pulse();
        chk("restart_count", bus.sym_count, 0);
        chk("restart_busy", bus.busy, 1);
        run_syms(REF_D + 150, WIN - 1, 0);
        chk("restart_done_early", bus.done, 0);
        run_syms(REF_D + 249, 1, 0);
        chk("restart_done", bus.done, 1);
        chk("restart_total", bus.sym_count, WIN);

        // Randomized samples, phases, references, strobes and starts.
        rph = 0;
        start_pulse();
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0:       iv = edge_v[$urandom_range(0, 5)];
                1:       iv = lvl(2'($urandom_range(0, 3)));
                default: iv = int'($urandom_range(0, 262143)) - 131072;
            endcase
            qv = int'($urandom_range(0, 262143)) - 131072;
            if ($urandom_range(0, 7) == 0) rph = 2'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, iv, qv, rph, $urandom_range(0, 2) == 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 199) == 0);
        end

        // Reset during a measurement at symbol 50.
        fill_syms();
        do_reset(2);
        start_pulse();
        for (int k = 0; k < 50; k++) send_sym(syms[k], 0, 2'd0, syms[k + 100]);
        do_reset(3);
        for (int k = 0; k < 10; k++) send_sym(syms[k], 0, 2'd0, syms[k + 1]);
        chk("post_rst_count", bus.sym_count, 0);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_done", bus.done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
